// File: rtl/register_file_param.sv
// Parameterised multi-port register file: two combinational read ports, one write port, and a sequential clear engine.
// Define RF_BYPASS_EN to make reads write-first; leave it undefined for read-first. Writes are dropped while busy is high.
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEn,
  input  logic              clearReq,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;

  assign busy  = (state_q == CLEAR);
  assign wr_en = writeEn && !busy && !((ZERO_REG != 0) && (writeAddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clearReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // cnt wraps to 0 naturally on the final clear edge
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[writeAddr] = writeData;
    if (busy)  regs_d[cnt_q]     = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
`ifdef RF_BYPASS_EN
    // Write-first forwarding; gated by reset so reset always reads zero
    if (writeEn && !busy && !rst && (a == writeAddr)) v = writeData;
`endif
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  assign readData1 = rd_port(readAddr1);
  assign readData2 = rd_port(readAddr2);

endmodule

// File: tb/tb_register_file_param.sv
// Randomised self-checking bench for register_file_param (ADDR_W=3) against an array/countdown reference model.
module tb_register_file_param;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] readAddr1, readAddr2, writeAddr;
  logic [DW-1:0] writeData;
  logic          writeEn, clearReq;
  logic [DW-1:0] readData1, readData2;
  logic          busy;

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .writeAddr(writeAddr), .writeData(writeData),
    .writeEn(writeEn), .clearReq(clearReq),
    .readData1(readData1), .readData2(readData2),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: contents array plus number of clear edges still to come
  logic [DW-1:0] mem [DEPTH];
  int            clear_left;
  logic          busy_seen;
  logic [DW-1:0] exp_bp;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    clear_left = 0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (writeEn && clear_left == 0 && !rst && a == writeAddr) return writeData;
`endif
    return mem[a];
  endfunction

  task automatic model_edge();
    if (rst) return;
    if (clear_left > 0) begin
      mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (writeEn && writeAddr != 0) mem[writeAddr] = writeData;
      if (clearReq) clear_left = DEPTH;
    end
  endtask

  // Inputs change at posedge+1; outputs are checked at negedge
  task automatic tick();
    @(negedge clk);
    busy_seen = busy;
    check("busy", {31'b0, busy}, {31'b0, clear_left > 0});
    check("rd1", readData1, exp_rd(readAddr1));
    check("rd2", readData2, exp_rd(readAddr2));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    writeEn = 1'b1; writeAddr = a; writeData = d;
    tick();
    writeEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  int busy_cnt;

  initial begin
    rst = 1'b1; writeEn = 0; clearReq = 0;
    readAddr1 = 0; readAddr2 = 0; writeAddr = 0; writeData = 0;
    model_reset();
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rd1", readData1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write/read
    readAddr1 = 3'd4; readAddr2 = 3'd0;
    write(3'd4, 32'h65655555);
    #1;
    check("basic_rd1", readData1, 32'h65655555);
    check("basic_rd2_zero", readData2, 32'd0);

    // Register 0 ignores writes
    readAddr2 = 3'd0;
    writeEn = 1'b1; writeAddr = 3'd0; writeData = 32'h00000564;
    #1 check("r0_before", readData2, 32'd0);
    tick(); writeEn = 1'b0;
    #1 check("r0_after", readData2, 32'd0);

    // Bypass / read-first
    readAddr1 = 3'd7;
    writeEn = 1'b1; writeAddr = 3'd7; writeData = 32'hDEADBEEF;
`ifdef RF_BYPASS_EN
    exp_bp = 32'hDEADBEEF;
`else
    exp_bp = 32'd0;
`endif
    #1 check("bypass", readData1, exp_bp);
    tick(); writeEn = 1'b0;
    #1 check("post_write7", readData1, 32'hDEADBEEF);

    // Clear sequence: busy for exactly DEPTH cycles, write at cycle 3 dropped
    for (int i = 1; i < DEPTH; i++) write(AW'(i), 32'h11111111 * i);
    clearReq = 1'b1; tick(); clearReq = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin writeEn = 1'b1; writeAddr = 3'd5; writeData = 32'h5555AAAA; end
      else writeEn = 1'b0;
      readAddr1 = AW'(i); readAddr2 = 3'd5;
      tick();
      if (busy_seen) busy_cnt++;
    end
    writeEn = 1'b0;
    check("clear_busy_cycles", busy_cnt, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      readAddr1 = AW'(a); #1;
      check("clear_zero", readData1, 32'd0);
    end

    // Reset in the middle of a clear
    for (int i = 1; i < DEPTH; i++) write(AW'(i), $urandom);
    clearReq = 1'b1; tick(); clearReq = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; model_reset(); #1;
    check("midclr_busy", {31'b0, busy}, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      readAddr1 = AW'(a); readAddr2 = AW'(DEPTH - 1 - a); #1;
      check("midclr_rd1", readData1, 32'd0);
      check("midclr_rd2", readData2, 32'd0);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Simultaneous write and clear request
    readAddr1 = 3'd2;
    writeEn = 1'b1; writeAddr = 3'd2; writeData = 32'hA5A5A5A5; clearReq = 1'b1;
    tick();
    writeEn = 1'b0; clearReq = 1'b0;
    #1 check("wrclr_written", readData1, 32'hA5A5A5A5);
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check("wrclr_cleared", readData1, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      readAddr1 = AW'($urandom_range(0, DEPTH - 1));
      readAddr2 = AW'($urandom_range(0, DEPTH - 1));
      writeEn   = ($urandom_range(0, 99) < 60);
      writeAddr = AW'($urandom_range(0, DEPTH - 1));
      writeData = $urandom;
      clearReq  = ($urandom_range(0, 99) < 4);
      if (!writeEn && $urandom_range(0, 3) == 0) begin
        writeAddr = 'x; writeData = 'x;
      end
      if ($urandom_range(0, 99) < 2) begin
        writeEn = 1'b0; clearReq = 1'b0;
        rst = 1'b1; model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
